// File: rtl/mbi_pkg.sv
// Shared types and address-field helpers for the multi-bank memory initiator.
package mbi_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } mbi_state_e;

  localparam int MBI_AW         = 11;
  localparam int BANK_HI        = 10;
  localparam int BANK_LO        = 9;
  localparam int SUB_HI         = 8;
  localparam int SUB_LO         = 7;
  localparam int WORD_HI        = 6;
  localparam int WORD_LO        = 0;
  localparam int ARRAY_SIZE     = 2048;
  localparam int CONFLICT_CNT_W = 16;

  // Bank and sub-bank fields are adjacent, so one slice covers both.
  function automatic logic same_subbank(input logic [MBI_AW-1:0] a,
                                        input logic [MBI_AW-1:0] b);
    return a[BANK_HI:SUB_LO] == b[BANK_HI:SUB_LO];
  endfunction

endpackage

// File: rtl/mbi_rsp_fifo.sv
// Synchronous response FIFO; output comes from storage only (no pass-through).
module mbi_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is reset too so the data output is defined while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_bank_initiator.sv
// Request-side controller for the 4x4x128 byte memory array with zero-clear.
// Optional macro MBI_CONFLICT_CNT_EN adds the conflict_cnt output and counter.
module mem_bank_initiator
  import mbi_pkg::*;
#(
  parameter int AW        = 11,
  parameter int DW        = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
`ifdef MBI_CONFLICT_CNT_EN
  ,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
`endif
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  mbi_state_e    state_q, state_d;
  logic          run_en_q;
  // [0]: read issued to the array (drives mem_ren), [1]: array data to capture.
  logic [1:0]    rd_vld_pipe_q, rd_vld_pipe_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          mem_wen_q, mem_wen_d;
  logic [AW-1:0] mem_raddr_q, mem_raddr_d;
  logic [AW-1:0] mem_waddr_q, mem_waddr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;

  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty, fifo_full;
  logic [CW:0]   credit_used;
  logic          run_ok, collide, rd_fire, wr_fire;

  // Occupancy plus in-flight reads bounds the FIFO, so it can never overflow.
  assign credit_used = {1'b0, fifo_cnt} + (CW+1)'(rd_vld_pipe_q[0])
                     + (CW+1)'(rd_vld_pipe_q[1]);
  assign run_ok   = run_en_q && (state_q == RUN) && !clr_start;
  assign rd_ready = run_ok && (credit_used < (CW+1)'(RSP_DEPTH));
  assign collide  = rd_valid && rd_ready && same_subbank(wr_addr, rd_addr);
  assign wr_ready = run_ok && !collide;
  assign rd_fire  = rd_valid && rd_ready;
  assign wr_fire  = wr_valid && wr_ready;

  assign clr_busy  = (state_q == CLEAR);
  assign clr_done  = (state_q == CLEAR) && (clr_addr_q == AW'(ARRAY_SIZE - 1));
  assign mem_ren   = rd_vld_pipe_q[0];
  assign mem_wen   = mem_wen_q;
  assign mem_raddr = mem_raddr_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_din   = mem_din_q;
  assign rsp_valid = !fifo_empty;

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    rd_vld_pipe_d = {rd_vld_pipe_q[0], rd_fire};
    mem_wen_d     = 1'b0;
    mem_raddr_d   = mem_raddr_q;
    mem_waddr_d   = mem_waddr_q;
    mem_din_d     = mem_din_q;
    case (state_q)
      RUN: begin
        if (rd_fire) mem_raddr_d = rd_addr;
        if (wr_fire) begin
          mem_wen_d   = 1'b1;
          mem_waddr_d = wr_addr;
          mem_din_d   = wr_data;
        end
        if (run_en_q && clr_start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        mem_wen_d   = 1'b1;
        mem_waddr_d = clr_addr_q;
        mem_din_d   = '0;
        clr_addr_d  = clr_addr_q + 1'b1;
        // Counter wrapping back to zero means the last address was just issued.
        if (clr_addr_d == '0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      run_en_q      <= 1'b0;
      rd_vld_pipe_q <= '0;
      clr_addr_q    <= '0;
      mem_wen_q     <= 1'b0;
      mem_raddr_q   <= '0;
      mem_waddr_q   <= '0;
      mem_din_q     <= '0;
    end else begin
      state_q       <= state_d;
      run_en_q      <= 1'b1;
      rd_vld_pipe_q <= rd_vld_pipe_d;
      clr_addr_q    <= clr_addr_d;
      mem_wen_q     <= mem_wen_d;
      mem_raddr_q   <= mem_raddr_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_din_q     <= mem_din_d;
    end
  end

  mbi_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (DW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_vld_pipe_q[1]),
    .din   (mem_dout),
    .pop   (rsp_ready),
    .dout  (rsp_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

`ifdef MBI_CONFLICT_CNT_EN
  logic [CONFLICT_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (wr_valid && run_ok && collide && (conflict_cnt_q != '1))
      conflict_cnt_d = conflict_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt_q <= '0;
    else        conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bank_initiator.sv
// Bench for mem_bank_initiator: array model, reference memory and response scoreboard.
module tb_mem_bank_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 0, rd_valid = 0, rsp_ready = 1, clr_start = 0;
  logic [10:0] wr_addr = 0, rd_addr = 0;
  logic [7:0]  wr_data = 0;
  logic        wr_ready, rd_ready, rsp_valid, clr_busy, clr_done;
  logic        mem_ren, mem_wen;
  logic [10:0] mem_raddr, mem_waddr;
  logic [7:0]  mem_din, mem_dout, rsp_data;
`ifdef MBI_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  always #5 clk = ~clk;

  mem_bank_initiator #(.AW(11), .DW(8), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef MBI_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // Array model: drops a write when a read targets the same sub-bank.
  logic [7:0] arr [2048];
  logic [7:0] dout_r;
  logic       dout_v;
  always @(posedge clk) begin
    if (mem_wen && !(mem_ren && mem_waddr[10:7] == mem_raddr[10:7])) arr[mem_waddr] <= mem_din;
    dout_r <= mem_ren ? arr[mem_raddr] : 8'h00;
    dout_v <= mem_ren;
  end
  assign mem_dout = dout_v ? dout_r : 8'h00;

  int checks = 0, errors = 0, cyc_n = 0, rsp_cnt = 0;
  logic [7:0] ref_mem [2048];
  logic [7:0] exp_q [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshakes are evaluated mid-cycle; inputs only change at negedge.
  task automatic mon();
    cyc_n++;
    if (rd_valid && rd_ready) exp_q.push_back(ref_mem[rd_addr]);
    if (wr_valid && wr_ready) ref_mem[wr_addr] = wr_data;
    if (rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got 0x%0h expected none", rsp_data);
      end else chk("rsp_data", rsp_data, exp_q.pop_front());
    end
  endtask

  task automatic cyc(bit wv, logic [10:0] wa, logic [7:0] wd, bit rv, logic [10:0] ra,
                     bit rr, bit cs);
    @(negedge clk);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; rsp_ready = rr; clr_start = cs;
    #1;
    mon();
  endtask

  task automatic idle(); cyc(0, 0, 0, 0, 0, 1, 0); endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) idle();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    bit          wv;
    logic [10:0] wa;
    logic [7:0]  wd;
    bit          rv;
    logic [10:0] ra;
    bit          exp_wr;
    bit          exp_rd;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, busy, done_cnt, done_at, leak, lat_cyc;

    tbl[0] = '{1, 11'h085, 8'h11, 0, 11'h000, 1, 1};
    tbl[1] = '{1, 11'h0A5, 8'h5A, 1, 11'h085, 0, 1};
    tbl[2] = '{1, 11'h0A5, 8'h5A, 0, 11'h000, 1, 1};
    tbl[3] = '{1, 11'h285, 8'h77, 1, 11'h085, 1, 1};
    tbl[4] = '{1, 11'h080, 8'h42, 1, 11'h0A5, 0, 1};
    tbl[5] = '{1, 11'h080, 8'h42, 1, 11'h285, 1, 1};
    tbl[6] = '{1, 11'h123, 8'h99, 1, 11'h123, 0, 1};
    tbl[7] = '{1, 11'h123, 8'h99, 1, 11'h080, 1, 1};
    tbl[8] = '{0, 11'h000, 8'h00, 1, 11'h123, 1, 1};
    tbl[9] = '{1, 11'h7FF, 8'hC3, 1, 11'h085, 1, 1};

    // Reset values
    #2;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_mem_en", {mem_ren, mem_wen}, 0);
    chk("rst_mem_addr", {mem_raddr, mem_waddr, mem_din, rsp_data}, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("ready_before_edge", rd_ready, 0);
    idle();
    chk("ready_after_release", {wr_ready, rd_ready}, 2'b11);

    // Read after write with exact latency
    cyc(1, 11'h123, 8'h3C, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 11'h123, 1, 0);
    chk("raw_rd_ready", rd_ready, 1);
    lat_cyc = cyc_n;
    idle(); chk("raw_mem_ren", mem_ren, 1); chk("raw_rsp_early1", rsp_valid, 0);
    idle(); chk("raw_rsp_early2", rsp_valid, 0);
    idle(); chk("raw_rsp_on_time", rsp_valid, 1); chk("raw_latency", cyc_n - lat_cyc, 3);
    chk("raw_data", rsp_data, 8'h3C);
    drain();

    // Collision / no-collision vectors
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, 1, 0);
      chk($sformatf("vec%0d_wr_ready", i), wr_ready, tbl[i].exp_wr);
      chk($sformatf("vec%0d_rd_ready", i), rd_ready, tbl[i].exp_rd);
    end
`ifdef MBI_CONFLICT_CNT_EN
    chk("conflict_cnt", conflict_cnt, 3);
`endif
    cyc(0, 0, 0, 1, 11'h0A5, 1, 0);
    cyc(0, 0, 0, 1, 11'h285, 1, 0);
    drain();

    // Backpressure: credits limit acceptance to the FIFO depth
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      logic [10:0] a;
      case (i)
        0: a = 11'h085; 1: a = 11'h0A5; 2: a = 11'h285;
        3: a = 11'h080; 4: a = 11'h123; default: a = 11'h7FF;
      endcase
      cyc(0, 0, 0, 1, a, 0, 0);
      chk($sformatf("bp%0d_rd_ready", i), rd_ready, (i < 4) ? 1 : 0);
      if (rd_ready) acc++;
    end
    chk("bp_accepted", acc, 4);
    rsp_cnt = 0;
    drain();
    chk("bp_responses", rsp_cnt, 4);
    cyc(0, 0, 0, 1, 11'h085, 1, 0);
    chk("bp_resume", rd_ready, 1);
    drain();

    // Full-array clear
    cyc(1, 11'h000, 8'hFF, 0, 0, 1, 0);
    cyc(1, 11'h7FF, 8'hFF, 0, 0, 1, 0);
    cyc(1, 11'h100, 8'h55, 1, 11'h000, 1, 1);
    chk("clr_start_blocks", {wr_ready, rd_ready, clr_busy}, 0);
    busy = 0; done_cnt = 0; done_at = 0; leak = 0;
    for (int i = 0; i < 3000; i++) begin
      bit act;
      act = (busy < 2000);
      cyc(act, 11'h100, 8'h55, act, 11'h000, 1, (i == 5));
      if (clr_busy) begin
        busy++;
        if (wr_ready || rd_ready || mem_ren) leak++;
      end
      if (clr_done) begin done_cnt++; done_at = busy; end
      if (!clr_busy && busy > 0) break;
    end
    chk("clr_busy_cycles", busy, 2048);
    chk("clr_done_count", done_cnt, 1);
    chk("clr_done_position", done_at, 2048);
    chk("clr_ready_leak", leak, 0);
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    cyc(0, 0, 0, 1, 11'h000, 1, 0);
    cyc(0, 0, 0, 1, 11'h7FF, 1, 0);
    drain();

    // Reset in the middle of a clear
    cyc(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 100; i++) idle();
    chk("mid_clr_busy", clr_busy, 1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mrst_ready", {wr_ready, rd_ready}, 0);
    chk("mrst_flags", {rsp_valid, clr_busy, clr_done}, 0);
    chk("mrst_mem_en", {mem_ren, mem_wen}, 0);
    chk("mrst_mem_addr", {mem_raddr, mem_waddr}, 0);
    chk("mrst_data", {mem_din, rsp_data}, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    idle();
    chk("mrst_run_state", {clr_busy, rd_ready, wr_ready}, 3'b011);
    cyc(0, 0, 0, 1, 11'h7FF, 1, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
